// File: rtl/dig_clk_enable_gen.sv
// dig_clk_enable_gen
//   Fractional clock-enable generator running on the DCM CLKFX clock. After a
//   fixed settle interval (DCM LOCKED is not available here) a phase
//   accumulator produces single-cycle tick enables at an average rate of
//   inc_act / 2^ACC_BITS per clock, plus a square wave sq that toggles on
//   every tick. New increments are handshaked and only take effect at an
//   accumulator wrap, so tick spacing never glitches.
//
// Ports
//   C      in   clock (DCM CLKFX output)
//   clr    in   synchronous active-high reset, highest priority
//   en     in   accumulate enable (only meaningful once running)
//   inc    in   [ACC_BITS] new increment, sampled when ld=1
//   ld     in   load request for inc
//   ready  out  settle interval elapsed, generator running
//   tick   out  one-cycle enable on accumulator carry
//   sq     out  toggles on every tick
//   ack    out  one-cycle pulse when a requested increment becomes active
//   phase  out  [ACC_BITS] registered accumulator value, only present when
//               DIG_CLK_ENABLE_GEN_PHASE_OUT_EN is defined
//
// State table
//   state     | meaning
//   S_SETTLE  | counting the settle interval; ld updates the increment at once
//   S_RUN     | accumulating; ld is queued and applied at the next wrap

module dig_clk_enable_gen #(
  parameter int unsigned         ACC_BITS      = 16,
  parameter logic [ACC_BITS-1:0] INC           = 16'h4000,
  parameter int unsigned         SETTLE_CYCLES = 1024
) (
  input  logic                C,
  input  logic                clr,
  input  logic                en,
  input  logic [ACC_BITS-1:0] inc,
  input  logic                ld,
  output logic                ready,
  output logic                tick,
  output logic                sq,
  output logic                ack
`ifdef DIG_CLK_ENABLE_GEN_PHASE_OUT_EN
  ,
  output logic [ACC_BITS-1:0] phase
`endif
);

  typedef enum logic {
    S_SETTLE = 1'b0,
    S_RUN    = 1'b1
  } state_t;

  // The settle counter compares against the last count value so that ready
  // rises on the SETTLE_CYCLES-th edge; a zero interval leaves on edge one.
  localparam logic [19:0] SETTLE_LAST =
    (SETTLE_CYCLES == 0) ? 20'd0 : 20'(SETTLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [19:0]         settle_cnt_q, settle_cnt_d;
  logic [ACC_BITS-1:0] acc_q, acc_d;
  logic [ACC_BITS-1:0] inc_act_q, inc_act_d;
  logic [ACC_BITS-1:0] pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic                ready_q, ready_d;
  logic                tick_q, tick_d;
  logic                sq_q, sq_d;
  logic                ack_q, ack_d;

  logic [ACC_BITS:0]   sum;
  logic                carry;
  logic                inc_zero;

  assign sum      = {1'b0, acc_q} + {1'b0, inc_act_q};
  assign carry    = sum[ACC_BITS];
  assign inc_zero = (inc_act_q == '0);

  always_ff @(posedge C) begin
    if (clr) begin
      state_q      <= S_SETTLE;
      settle_cnt_q <= '0;
      acc_q        <= '0;
      inc_act_q    <= INC;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      ready_q      <= 1'b0;
      tick_q       <= 1'b0;
      sq_q         <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      acc_q        <= acc_d;
      inc_act_q    <= inc_act_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      ready_q      <= ready_d;
      tick_q       <= tick_d;
      sq_q         <= sq_d;
      ack_q        <= ack_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    acc_d        = acc_q;
    inc_act_d    = inc_act_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    ready_d      = ready_q;
    tick_d       = 1'b0;
    sq_d         = sq_q;
    ack_d        = 1'b0;

    if (state_q == S_SETTLE) begin
      settle_cnt_d = settle_cnt_q + 20'd1;
      // Nothing is being generated yet, so the new rate can take over at once.
      if (ld) begin
        inc_act_d = inc;
        ack_d     = 1'b1;
      end
      if (settle_cnt_q == SETTLE_LAST) begin
        state_d = S_RUN;
        ready_d = 1'b1;
      end
    end else begin
      ready_d = 1'b1;
      if (en) begin
        acc_d  = sum[ACC_BITS-1:0];
        tick_d = carry;
        sq_d   = sq_q ^ carry;
        if (ld && carry) begin
          // Fresh request on a wrap edge supersedes anything still queued.
          inc_act_d  = inc;
          pend_vld_d = 1'b0;
          ack_d      = 1'b1;
        end else if (ld) begin
          pend_d     = inc;
          pend_vld_d = 1'b1;
        end else if (pend_vld_q && (carry || inc_zero)) begin
          // A zero increment never wraps, so apply on the next enabled edge.
          inc_act_d  = pend_q;
          pend_vld_d = 1'b0;
          ack_d      = 1'b1;
        end
      end else if (ld) begin
        pend_d     = inc;
        pend_vld_d = 1'b1;
      end
    end
  end

  assign ready = ready_q;
  assign tick  = tick_q;
  assign sq    = sq_q;
  assign ack   = ack_q;

`ifdef DIG_CLK_ENABLE_GEN_PHASE_OUT_EN
  assign phase = acc_q;
`endif

endmodule
